// File: rtl/dma_pkg.sv
// dma_pkg: shared DMA AXI request/response types, descriptor and scheduler state
package dma_pkg;
  localparam int DMA_ADDR_W = 32;
  localparam int DMA_DATA_BYTES = 64;
  localparam logic [31:0] AXI_4KB = 32'd4096;
  typedef logic [7:0] axi_len_t;
  typedef struct packed {
    logic [DMA_ADDR_W-1:0]     addr;
    axi_len_t                  alen;
    logic [2:0]                size;
    logic [DMA_DATA_BYTES-1:0] strb;
    logic                      valid;
  } s_dma_axi_req_t;
  typedef struct packed {
    logic ready;
    logic finish;
  } s_dma_axi_resp_t;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} e_sched_state_t;
  typedef struct packed {
    logic [DMA_ADDR_W-1:0] src;
    logic [DMA_ADDR_W-1:0] dst;
    logic [31:0]           bytes;
  } s_dma_desc_t;
endpackage

// File: rtl/dma_len_fifo.sv
// dma_len_fifo: synchronous FIFO of burst lengths handed from read issue to write issue
// ports: push/din write, pop advances head, clr empties, full/empty flags
module dma_len_fifo
  import dma_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     clr,
  input  logic     push,
  input  logic     pop,
  input  axi_len_t din,
  output axi_len_t head,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  axi_len_t mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign head = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + ONE;
      if (pop && !empty) rp <= rp + ONE;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/dma_burst_scheduler.sv
// dma_burst_scheduler: splits one DMA descriptor into credit-throttled AXI read bursts and matching write bursts
// ports: desc_* descriptor handshake, dma_active_i abort when low, rd/wr_req_o burst requests,
//        rd/wr_resp_i address-accept and burst-finish, busy_o/done_o/desc_err_o status
module dma_burst_scheduler
  import dma_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_BYTES  = 64,
  parameter int MAX_BURST_BEATS = 16,
  parameter int FIFO_DEPTH      = 16,
  parameter int LEN_Q_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      desc_valid_i,
  output logic                      desc_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] desc_src_i,
  input  logic [AXI_ADDR_WIDTH-1:0] desc_dst_i,
  input  logic [31:0]               desc_bytes_i,
  input  logic                      dma_active_i,
  output s_dma_axi_req_t            rd_req_o,
  input  s_dma_axi_resp_t           rd_resp_i,
  output s_dma_axi_req_t            wr_req_o,
  input  s_dma_axi_resp_t           wr_resp_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      desc_err_o
);
  localparam int LOG2B = $clog2(AXI_DATA_BYTES);
  e_sched_state_t state, state_nx;
  // desc.src/bytes advance with read issue, desc.dst advances with write completion
  s_dma_desc_t desc;
  // destination address of the next read burst, used for its 4 KB split
  logic [DMA_ADDR_W-1:0] rd_dst;
  logic [15:0] credits, rd_out;
  logic wr_open, done_q, err_q;
  axi_len_t wr_alen, q_head;
  logic [31:0] rem_beats, src_room, dst_room, beats, burst_bytes;
  logic accept, bad, credit_ok, rd_acc, wr_acc, wr_fin, q_full, q_empty;
  assign desc_ready_o = state == IDLE;
  assign accept = desc_ready_o && desc_valid_i && dma_active_i;
  assign bad = |{desc_src_i[LOG2B-1:0], desc_dst_i[LOG2B-1:0], desc_bytes_i[LOG2B-1:0]};
  assign busy_o = state != IDLE || rd_out != '0;
  assign done_o = done_q;
  assign desc_err_o = err_q;
  always_comb begin
    rem_beats = desc.bytes >> LOG2B;
    src_room = (AXI_4KB - {20'd0, desc.src[11:0]}) >> LOG2B;
    dst_room = (AXI_4KB - {20'd0, rd_dst[11:0]}) >> LOG2B;
    beats = 32'(MAX_BURST_BEATS);
    beats = rem_beats < beats ? rem_beats : beats;
    beats = src_room < beats ? src_room : beats;
    beats = dst_room < beats ? dst_room : beats;
    burst_bytes = beats << LOG2B;
    credit_ok = 32'(credits) + beats <= 32'(FIFO_DEPTH);
    rd_req_o.addr = desc.src;
    rd_req_o.alen = axi_len_t'(beats - 32'd1);
    rd_req_o.size = 3'(LOG2B);
    rd_req_o.strb = '1;
    rd_req_o.valid = dma_active_i && state == ISSUE && !q_full && credit_ok;
    wr_req_o.addr = desc.dst;
    wr_req_o.alen = q_head;
    wr_req_o.size = 3'(LOG2B);
    wr_req_o.strb = '1;
    wr_req_o.valid = dma_active_i && !q_empty && !wr_open;
    rd_acc = rd_req_o.valid && rd_resp_i.ready;
    wr_acc = wr_req_o.valid && wr_resp_i.ready;
    wr_fin = wr_open && wr_resp_i.finish;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && !bad) state_nx = desc_bytes_i == '0 ? DONE : ISSUE;
      ISSUE:   if (rd_acc && rem_beats == beats) state_nx = DRAIN;
      DRAIN:   if (q_empty && !wr_open && credits == '0) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (!dma_active_i) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      desc <= '0;
      rd_dst <= '0;
      credits <= '0;
      rd_out <= '0;
      wr_open <= 1'b0;
      wr_alen <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else if (!dma_active_i) begin
      desc <= '0;
      rd_dst <= '0;
      credits <= '0;
      rd_out <= '0;
      wr_open <= 1'b0;
      wr_alen <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      done_q <= state == DONE;
      err_q <= accept && bad;
      if (accept) begin
        desc <= '{src: DMA_ADDR_W'(desc_src_i), dst: DMA_ADDR_W'(desc_dst_i), bytes: desc_bytes_i};
        rd_dst <= DMA_ADDR_W'(desc_dst_i);
      end
      if (rd_acc) begin
        desc.src <= desc.src + burst_bytes;
        desc.bytes <= desc.bytes - burst_bytes;
        rd_dst <= rd_dst + burst_bytes;
      end
      if (wr_acc) begin
        wr_open <= 1'b1;
        wr_alen <= q_head;
      end
      if (wr_fin) begin
        wr_open <= 1'b0;
        desc.dst <= desc.dst + ((32'(wr_alen) + 32'd1) << LOG2B);
      end
      // read accept and write release may land on the same edge; both apply
      credits <= credits + (rd_acc ? beats[15:0] : 16'd0) - (wr_fin ? 16'(wr_alen) + 16'd1 : 16'd0);
      rd_out <= rd_out + 16'(rd_acc) - 16'(rd_resp_i.finish && (rd_out != '0 || rd_acc));
    end
  dma_len_fifo #(.DEPTH(LEN_Q_DEPTH)) u_len_q (
    .clk  (clk),
    .rstn (rstn),
    .clr  (!dma_active_i),
    .push (rd_acc),
    .pop  (wr_acc),
    .din  (rd_req_o.alen),
    .head (q_head),
    .full (q_full),
    .empty(q_empty)
  );
endmodule

// File: tb/tb_dma_burst_scheduler.sv
// tb_dma_burst_scheduler: randomized scoreboard bench with a burst-list reference model
module tb_dma_burst_scheduler;
  import dma_pkg::*;
  typedef struct {
    logic [31:0] addr;
    int unsigned alen;
  } burst_t;
  logic clk = 1'b0, rstn = 1'b0, desc_valid = 1'b0, dma_active = 1'b1;
  logic desc_ready, busy, done, desc_err;
  logic [31:0] desc_src = '0, desc_dst = '0, desc_bytes = '0;
  s_dma_axi_req_t rd_req, wr_req;
  s_dma_axi_resp_t rd_resp = '0, wr_resp = '0;
  burst_t rd_exp[$], wr_exp[$];
  int n_vec = 0, n_fail = 0, cyc = 0;
  int rd_rdy_mode = 1, wr_rdy_mode = 1, wdelay = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dma_burst_scheduler dut (
    .clk         (clk),
    .rstn        (rstn),
    .desc_valid_i(desc_valid),
    .desc_ready_o(desc_ready),
    .desc_src_i  (desc_src),
    .desc_dst_i  (desc_dst),
    .desc_bytes_i(desc_bytes),
    .dma_active_i(dma_active),
    .rd_req_o    (rd_req),
    .rd_resp_i   (rd_resp),
    .wr_req_o    (wr_req),
    .wr_resp_i   (wr_resp),
    .busy_o      (busy),
    .done_o      (done),
    .desc_err_o  (desc_err)
  );
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic miss(input string nm);
    n_vec++;
    n_fail++;
    $display("FAIL %s: event not expected at cycle %0d", nm, cyc);
  endtask
  // reference: walk the transfer in bursts capped by length, 16 beats and both 4 KB pages
  task automatic model(input logic [31:0] s, input logic [31:0] d, input logic [31:0] b);
    int unsigned rem = b / 64, bt, room;
    logic [31:0] sa = s, da = d;
    while (rem > 0) begin
      bt = rem > 16 ? 16 : rem;
      room = (4096 - sa % 4096) / 64;
      if (room < bt) bt = room;
      room = (4096 - da % 4096) / 64;
      if (room < bt) bt = room;
      rd_exp.push_back('{sa, bt - 1});
      wr_exp.push_back('{da, bt - 1});
      sa += bt * 64;
      da += bt * 64;
      rem -= bt;
    end
  endtask
  // AXI responder: random or fixed ready, read finish after the burst's beats, write finish after wdelay
  initial begin
    logic rd_hs, wr_hs, wr_pend;
    int unsigned nb;
    int wr_cnt;
    int unsigned rd_left[$];
    wr_pend = 1'b0;
    wr_cnt = 0;
    forever begin
      @(negedge clk);
      rd_hs = rd_req.valid && rd_resp.ready;
      nb = 32'(rd_req.alen) + 1;
      wr_hs = wr_req.valid && wr_resp.ready;
      @(posedge clk);
      #1;
      rd_resp.finish = 1'b0;
      if (rd_left.size() > 0) begin
        if (rd_left[0] <= 1) begin
          rd_resp.finish = 1'b1;
          void'(rd_left.pop_front());
        end else rd_left[0]--;
      end
      if (rd_hs) rd_left.push_back(nb);
      wr_resp.finish = 1'b0;
      if (wr_pend) begin
        if (wr_cnt == 0) begin
          wr_resp.finish = 1'b1;
          wr_pend = 1'b0;
        end else wr_cnt--;
      end
      if (wr_hs) begin
        wr_pend = 1'b1;
        wr_cnt = wdelay < 0 ? int'($urandom_range(0, 8)) : wdelay;
      end
      rd_resp.ready = rd_rdy_mode == 1 ? 1'b1 : rd_rdy_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
      wr_resp.ready = wr_rdy_mode == 1 ? 1'b1 : wr_rdy_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end
  // monitor: every accepted burst is popped from the expected queues and compared
  initial begin
    logic rw;
    logic [31:0] ra;
    axi_len_t rl;
    burst_t e;
    rw = 1'b0;
    ra = '0;
    rl = '0;
    forever begin
      @(negedge clk);
      if (rstn && rw && dma_active) begin
        check("rd_hold_valid", 64'(rd_req.valid), 64'(1));
        check("rd_hold_addr", 64'(rd_req.addr), 64'(ra));
        check("rd_hold_alen", 64'(rd_req.alen), 64'(rl));
      end
      rw = rd_req.valid && !rd_resp.ready;
      ra = rd_req.addr;
      rl = rd_req.alen;
      if (rd_req.valid && rd_resp.ready) begin
        if (rd_exp.size() == 0) miss("rd_unexpected");
        else begin
          e = rd_exp.pop_front();
          check("rd_addr", 64'(rd_req.addr), 64'(e.addr));
          check("rd_alen", 64'(rd_req.alen), 64'(e.alen));
          check("rd_size", 64'(rd_req.size), 64'(6));
          check("rd_strb", rd_req.strb, {64{1'b1}});
        end
      end
      if (wr_req.valid && wr_resp.ready) begin
        if (wr_exp.size() == 0) miss("wr_unexpected");
        else begin
          e = wr_exp.pop_front();
          check("wr_addr", 64'(wr_req.addr), 64'(e.addr));
          check("wr_alen", 64'(wr_req.alen), 64'(e.alen));
          check("wr_size", 64'(wr_req.size), 64'(6));
        end
      end
    end
  end
  task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [31:0] b);
    check("desc_ready_pre", 64'(desc_ready), 64'(1));
    if (((s | d | b) & 32'h3F) == 0) model(s, d, b);
    desc_src = s;
    desc_dst = d;
    desc_bytes = b;
    desc_valid = 1'b1;
    @(posedge clk);
    #1;
    desc_valid = 1'b0;
  endtask
  task automatic finish_desc();
    int t = 0;
    while (!done && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("done_seen", 64'(done), 64'(1));
    check("rd_exp_left", 64'(rd_exp.size()), 64'(0));
    check("wr_exp_left", 64'(wr_exp.size()), 64'(0));
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(done), 64'(0));
    t = 0;
    while (busy && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("busy_drop", 64'(busy), 64'(0));
  endtask
  task automatic run_desc(input logic [31:0] s, input logic [31:0] d, input logic [31:0] b);
    issue(s, d, b);
    if (((s | d | b) & 32'h3F) != 0) begin
      check("err_pulse", 64'(desc_err), 64'(1));
      check("err_ready", 64'(desc_ready), 64'(1));
      check("err_no_rd", 64'(rd_req.valid), 64'(0));
      @(posedge clk);
      #1;
      check("err_clear", 64'(desc_err), 64'(0));
      check("err_ready2", 64'(desc_ready), 64'(1));
      check("err_busy", 64'(busy), 64'(0));
    end else if (b == 0) begin
      check("zero_done_c1", 64'(done), 64'(0));
      check("zero_no_rd", 64'(rd_req.valid), 64'(0));
      @(posedge clk);
      #1;
      check("zero_done_c2", 64'(done), 64'(1));
      check("zero_no_wr", 64'(wr_req.valid), 64'(0));
      @(posedge clk);
      #1;
      check("zero_done_c3", 64'(done), 64'(0));
    end else finish_desc();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: bench stuck at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int t, fin, rv;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(desc_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(desc_err), 64'(0));
    check("rst_rd_valid", 64'(rd_req.valid), 64'(0));
    check("rst_wr_valid", 64'(wr_req.valid), 64'(0));
    rstn = 1'b1;
    @(posedge clk);
    #1;
    run_desc(32'h1000, 32'h2000, 1024);
    run_desc(32'h0FC0, 32'h3000, 256);
    wdelay = 50;
    issue(32'h8000, 32'h9000, 2048);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(rd_req.valid && rd_resp.ready) && t < 200);
    fin = -1;
    rv = -1;
    for (int i = 0; i < 300 && rv < 0; i++) begin
      @(negedge clk);
      if (rd_req.valid) rv = cyc;
      else if (wr_resp.finish && fin < 0) fin = cyc;
    end
    check("wr_fin_seen", 64'(fin >= 0), 64'(1));
    check("rd2_after_fin", 64'(rv), 64'(fin + 1));
    finish_desc();
    wdelay = 0;
    run_desc(32'h4000, 32'h5000, 0);
    run_desc(32'h1004, 32'h2000, 64);
    rd_rdy_mode = 2;
    issue(32'h5000, 32'h6000, 512);
    check("abort_rd_valid_pre", 64'(rd_req.valid), 64'(1));
    dma_active = 1'b0;
    #1;
    check("abort_rd_drop", 64'(rd_req.valid), 64'(0));
    check("abort_wr_drop", 64'(wr_req.valid), 64'(0));
    @(posedge clk);
    #1;
    dma_active = 1'b1;
    check("abort_idle", 64'(desc_ready), 64'(1));
    check("abort_busy", 64'(busy), 64'(0));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", 64'(done), 64'(0));
      check("abort_no_rd", 64'(rd_req.valid), 64'(0));
    end
    rd_exp.delete();
    wr_exp.delete();
    rd_rdy_mode = 1;
    run_desc(32'h7F80, 32'h10FC0, 512);
    rd_rdy_mode = 0;
    wr_rdy_mode = 0;
    wdelay = -1;
    for (int i = 0; i < 15; i++)
      run_desc(32'($urandom_range(0, 4095)) << 6, 32'($urandom_range(0, 4095)) << 6,
               32'($urandom_range(1, 48)) << 6);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_burst_scheduler.md
Name: dma_burst_scheduler

Overview:
- Sequences one DMA descriptor (src, dst, byte count) into a stream of AXI INCR read bursts and matching write bursts.
- Drives the streamer-side request ports of the DMA AXI interface (read and write `s_dma_axi_req_t`).
- Splits transfers at the 4 KB boundary and at MAX_BURST_BEATS.
- Throttles reads with a FIFO-space credit scheme, so data read ahead never exceeds the data FIFO depth.

Parameters:
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_BYTES, 64, bus width in bytes (512-bit data).
- MAX_BURST_BEATS, 16, maximum beats per burst (power of two, ≤256).
- FIFO_DEPTH, 16, data FIFO depth in beats; sets the read credit budget.
- LEN_Q_DEPTH, 4, depth of the pending-burst queue.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- desc_valid_i  in  1  descriptor valid
- desc_ready_o  out  1  scheduler idle, descriptor accepted on valid&&ready
- desc_src_i  in  AXI_ADDR_WIDTH  source byte address
- desc_dst_i  in  AXI_ADDR_WIDTH  destination byte address
- desc_bytes_i  in  32  transfer length in bytes
- dma_active_i  in  1  FSM RUN; low aborts
- rd_req_o  out  s_dma_axi_req_t  read burst request (addr, alen, size, strb, valid)
- rd_resp_i  in  s_dma_axi_resp_t  ready = address accepted; finish = rlast beat accepted
- wr_req_o  out  s_dma_axi_req_t  write burst request
- wr_resp_i  in  s_dma_axi_resp_t  ready = address accepted; finish = wlast beat sent
- busy_o  out  1  descriptor in progress
- done_o  out  1  one-cycle pulse, descriptor complete
- desc_err_o  out  1  one-cycle pulse, descriptor rejected

Behaviour:
- Reset values: all outputs 0 except desc_ready_o = 1. State IDLE, counters 0, queue empty.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - desc_ready_o = 1.
  - On accept, src/dst/bytes are latched.
  - If src, dst or bytes is not a multiple of AXI_DATA_BYTES: desc_err_o pulses next cycle, stay IDLE.
  - If bytes == 0: go to DONE.
  - Otherwise go to ISSUE.
- Beat count of the next burst, combinational from the latched state:
  - beats = min(remaining_beats, MAX_BURST_BEATS, (4096 − src[11:0])/AXI_DATA_BYTES, (4096 − dst[11:0])/AXI_DATA_BYTES).
  - alen = beats − 1.
  - size = log2(AXI_DATA_BYTES).
  - strb = all ones.
- Read issue (ISSUE):
  - rd_req_o.valid asserts when the length queue is not full and credits_used + beats ≤ FIFO_DEPTH.
  - Once asserted, addr, alen and valid are held stable until rd_resp_i.ready.
  - On ready, in the same edge: push alen into the queue, src += beats·AXI_DATA_BYTES, credits_used += beats, remaining −= beats.
  - Next request no earlier than the following cycle.
- Write issue: independent of read issue.
  - wr_req_o.valid asserts when the queue is not empty and no write burst is currently open (one write burst outstanding at the aw/w level).
  - addr = dst, alen = queue head.
  - On wr_resp_i.ready: mark the write open and pop the queue; the popped alen is kept in a register.
  - On wr_resp_i.finish: close the write, dst += (alen+1)·AXI_DATA_BYTES, credits_used −= alen+1.
- Simultaneous events:
  - Credit add (read accept) and credit release (write finish) in the same cycle net correctly.
  - Queue push and pop in the same cycle are legal when not full/empty.
- ISSUE → DRAIN when remaining reaches 0.
- DRAIN → DONE when the queue is empty, no write is open, and credits_used == 0.
- DONE: done_o = 1 for one cycle, then IDLE.
- rd_resp_i.finish is counted only to track outstanding reads.
  - busy_o = (state ≠ IDLE) || reads_outstanding ≠ 0.
- Abort: dma_active_i low in any state forces IDLE next cycle.
  - Clears counters and the queue; request valids drop immediately (combinationally gated).
  - No done_o pulse.
- Reset mid-operation: same as reset values, no pulse.

Decomposition:
- Add to dma_pkg:
  - AXI_4KB constant.
  - e_sched_state_t enum {IDLE, ISSUE, DRAIN, DONE}.
  - s_dma_desc_t struct (src, dst, bytes).
  - Reuse existing s_dma_axi_req_t, s_dma_axi_resp_t and axi_len_t.
- One sub-module: dma_len_fifo.
  - Synchronous FIFO of axi_len_t, LEN_Q_DEPTH entries.
  - Ports push/pop/full/empty/head.
  - Pointer wrap uses an extra MSB.

Test Plan:
- src=0x1000, dst=0x2000, bytes=1024, DMA responder with ready=1:
  - Expect one read with alen=15, addr 0x1000, then one write with alen=15, addr 0x2000.
  - done_o pulses once after the write finish; busy_o then drops.
- src=0x0FC0, dst=0x3000, bytes=256:
  - Read bursts (0x0FC0, alen=0) then (0x1000, alen=2).
  - Write bursts (0x3000, alen=0) then (0x3040, alen=2).
- bytes=2048, FIFO_DEPTH=16, write finish delayed 50 cycles:
  - Second read valid stays low until the first write's finish, then asserts within 1 cycle.
- bytes=0 → no rd/wr valid; done_o pulses exactly 2 cycles after accept.
- src=0x1004 → desc_err_o pulses, no requests, desc_ready_o remains 1.
- dma_active_i dropped while a read is waiting for ready:
  - Valids drop in the same cycle; IDLE next cycle; no done_o.
  - A new descriptor then runs correctly.
